// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the E-stage multiply/divide unit: md_op encodings,
// default multi-cycle latencies and small arithmetic helpers.
// -----------------------------------------------------------------------------
package md_unit_pkg;

  localparam int MD_WORD_W      = 32;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  // True for the four ops that launch a multi-cycle operation.
  function automatic logic md_is_start_op(input logic [2:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the ops that take the multiply latency (the rest take divide).
  function automatic logic md_is_mult_op(input logic [2:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU: r = 1'b1;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

  // Two's-complement negate of a data word.
  function automatic logic [MD_WORD_W-1:0] md_neg(input logic [MD_WORD_W-1:0] v);
    return (~v) + {{(MD_WORD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
// Bundle between the E-stage controller (master) and the md unit (slave).
//   md_en/md_op/a/b : request from the pipeline
//   busy            : operation starting or in progress (to D-stage stall logic)
//   md_out          : mfhi/mflo result for the E-stage result mux
//   hi/lo           : architectural HI/LO registers
// -----------------------------------------------------------------------------
interface md_unit_if;
  import md_unit_pkg::*;

  logic                 md_en;
  logic [2:0]           md_op;
  logic [MD_WORD_W-1:0] a;
  logic [MD_WORD_W-1:0] b;
  logic                 busy;
  logic [MD_WORD_W-1:0] md_out;
  logic [MD_WORD_W-1:0] hi;
  logic [MD_WORD_W-1:0] lo;

  modport master (
    output md_en, md_op, a, b,
    input  busy, md_out, hi, lo
  );

  modport slave (
    input  md_en, md_op, a, b,
    output busy, md_out, hi, lo
  );

endinterface

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit with HI/LO registers.
//   clk   : pipeline clock
//   reset : asynchronous, active-high; clears counter, shadow and HI/LO
//   md    : md_unit_if.slave (md_en, md_op, a, b -> busy, md_out, hi, lo)
// The full 64-bit result is computed in the start cycle and parked in shadow
// registers; it is committed to HI/LO on the edge where the counter hits 1,
// so HI/LO only change when the modelled latency has elapsed.
// -----------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [MD_WORD_W-1:0] WORD_ZERO = {MD_WORD_W{1'b0}};
  localparam logic [MD_WORD_W-1:0] WORD_ONE  = {{(MD_WORD_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]     cnt_q,  cnt_d;
  logic [MD_WORD_W-1:0] hi_q,   hi_d;
  logic [MD_WORD_W-1:0] lo_q,   lo_d;
  logic [MD_WORD_W-1:0] s_hi_q, s_hi_d;
  logic [MD_WORD_W-1:0] s_lo_q, s_lo_d;

  logic                 cnt_idle_s;
  logic                 start_s;
  logic                 b_zero_s;
  logic [63:0]          smul_s;
  logic [63:0]          umul_s;
  logic [MD_WORD_W-1:0] abs_a_s, abs_b_s, sdiv_b_s, uq_s, ur_s, sq_s, sr_s;
  logic [MD_WORD_W-1:0] udiv_b_s, udq_s, udr_s;
  logic [MD_WORD_W-1:0] res_hi_s, res_lo_s;
  logic [MD_WORD_W-1:0] md_out_s;

  assign cnt_idle_s = (cnt_q == CNT_ZERO);
  // Gated by reset so busy falls as soon as reset is asserted, even if the
  // pipeline keeps presenting a start-class op.
  assign start_s    = ~reset & md.md_en & md_is_start_op(md.md_op) & cnt_idle_s;

  // Product, quotient and remainder for all four start-class ops.
  always_comb begin
    b_zero_s = (md.b == WORD_ZERO);
    smul_s   = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    umul_s   = {32'd0, md.a} * {32'd0, md.b};

    // Signed divide via magnitudes: truncation toward zero and the
    // 0x80000000 / -1 case both fall out without special handling.
    abs_a_s  = md.a[31] ? md_neg(md.a) : md.a;
    abs_b_s  = md.b[31] ? md_neg(md.b) : md.b;
    // Divisor forced to 1 on zero only to keep the operator defined; the
    // result is discarded in that case.
    sdiv_b_s = b_zero_s ? WORD_ONE : abs_b_s;
    uq_s     = abs_a_s / sdiv_b_s;
    ur_s     = abs_a_s % sdiv_b_s;
    sq_s     = (md.a[31] ^ md.b[31]) ? md_neg(uq_s) : uq_s;
    sr_s     = md.a[31] ? md_neg(ur_s) : ur_s;

    udiv_b_s = b_zero_s ? WORD_ONE : md.b;
    udq_s    = md.a / udiv_b_s;
    udr_s    = md.a % udiv_b_s;

    case (md.md_op)
      MD_MULT:  {res_hi_s, res_lo_s} = smul_s;
      MD_MULTU: {res_hi_s, res_lo_s} = umul_s;
      // Divide by zero shadows the current HI/LO so completion is a no-op.
      MD_DIV:   {res_hi_s, res_lo_s} = b_zero_s ? {hi_q, lo_q} : {sr_s, sq_s};
      MD_DIVU:  {res_hi_s, res_lo_s} = b_zero_s ? {hi_q, lo_q} : {udr_s, udq_s};
      default:  {res_hi_s, res_lo_s} = {hi_q, lo_q};
    endcase
  end

  // Next-state: start, count down/commit, or mthi/mtlo when idle.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    s_hi_d = s_hi_q;
    s_lo_d = s_lo_q;
    if (start_s) begin
      s_hi_d = res_hi_s;
      s_lo_d = res_lo_s;
      cnt_d  = md_is_mult_op(md.md_op) ? MULT_LOAD : DIV_LOAD;
    end else if (!cnt_idle_s) begin
      // Any md request here (mthi/mtlo/restart) is ignored; the stall
      // controller is responsible for not issuing them.
      if (cnt_q == CNT_ONE) begin
        hi_d = s_hi_q;
        lo_d = s_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
      cnt_d = cnt_q - CNT_ONE;
    end else if (md.md_en) begin
      case (md.md_op)
        MD_MTHI: hi_d = md.a;
        MD_MTLO: lo_d = md.a;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= CNT_ZERO;
      hi_q   <= WORD_ZERO;
      lo_q   <= WORD_ZERO;
      s_hi_q <= WORD_ZERO;
      s_lo_q <= WORD_ZERO;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      s_hi_q <= s_hi_d;
      s_lo_q <= s_lo_d;
    end
  end

  // mfhi/mflo read-out; returns the committed register even mid-operation.
  always_comb begin
    md_out_s = WORD_ZERO;
    if (md.md_en) begin
      case (md.md_op)
        MD_MFHI: md_out_s = hi_q;
        MD_MFLO: md_out_s = lo_q;
        default: md_out_s = WORD_ZERO;
      endcase
    end else begin
      md_out_s = WORD_ZERO;
    end
  end

  assign md.busy   = start_s | ~cnt_idle_s;
  assign md.md_out = md_out_s;
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if ifc();
  md_unit dut (.clk(clk), .reset(reset), .md(ifc));

  int total = 0;
  int bad   = 0;

  // Architectural HI/LO as the bench expects them after all issued ops finish.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];

  // Reference model: returns {hi, lo} after the op completes.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] ch,
                                        input logic [31:0] cl);
    int          sa, sb, q, r;
    longint      sp;
    longint unsigned up;
    sa = av;
    sb = bv;
    case (op)
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return 64'(sp);
      end
      MD_MULTU: begin
        up = 64'(av) * 64'(bv);
        return 64'(up);
      end
      MD_DIV: begin
        if (bv == 32'd0) return {ch, cl};
        if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      MD_DIVU: begin
        if (bv == 32'd0) return {ch, cl};
        return {av % bv, av / bv};
      end
      default: return {ch, cl};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv);
    ifc.md_en = en;
    ifc.md_op = op;
    ifc.a     = av;
    ifc.b     = bv;
  endtask

  // Drive a start-class op and push its expected completion to the scoreboard.
  task automatic start_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] r;
    r = model(op, av, bv, m_hi, m_lo);
    m_hi = r[63:32];
    m_lo = r[31:0];
    exp_hi_q.push_back(m_hi);
    exp_lo_q.push_back(m_lo);
    drive(1'b1, op, av, bv);
  endtask

  // Count cycles with busy high starting in the current (start) cycle.
  task automatic count_busy(output int n, output bit timeout);
    n = 0;
    timeout = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ifc.busy !== 1'b1) return;
      n++;
      tick();
      ifc.md_en = 1'b0;
    end
    timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, MD_MULT, 32'd0, 32'd0);
    tick();
    tick();
    #1;
    total++; if (ifc.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", ifc.busy); bad++; end
    total++; if (ifc.hi !== 32'd0) begin $display("FAIL reset_hi: got %h want 0", ifc.hi); bad++; end
    total++; if (ifc.lo !== 32'd0) begin $display("FAIL reset_lo: got %h want 0", ifc.lo); bad++; end
    total++; if (ifc.md_out !== 32'd0) begin $display("FAIL reset_md_out: got %h want 0", ifc.md_out); bad++; end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_en_low();
    drive(1'b0, MD_MTHI, 32'hDEADBEEF, 32'd0);
    #1;
    total++; if (ifc.md_out !== 32'd0) begin $display("FAIL enlow_md_out: got %h want 0", ifc.md_out); bad++; end
    total++; if (ifc.busy !== 1'b0) begin $display("FAIL enlow_busy: got %b want 0", ifc.busy); bad++; end
    tick();
    total++; if (ifc.hi !== m_hi) begin $display("FAIL enlow_hi: got %h want %h", ifc.hi, m_hi); bad++; end
  endtask

  task automatic test_arith();
    logic [2:0]  t_op [7];
    logic [31:0] t_a  [7];
    logic [31:0] t_b  [7];
    int          t_n  [7];
    int          n;
    bit          to;
    logic [31:0] eh, el;
    t_op = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV, MD_DIV, MD_DIVU, MD_DIVU};
    t_a  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd7};
    t_b  = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd16, 32'd0};
    t_n  = '{6, 6, 11, 11, 11, 11, 11};
    for (int k = 0; k < 7; k++) begin
      start_op(t_op[k], t_a[k], t_b[k]);
      count_busy(n, to);
      total++;
      if (to || n != t_n[k]) begin
        $display("FAIL arith%0d_busy_cycles: got %0d (timeout=%0b) want %0d", k, n, to, t_n[k]);
        bad++;
      end
      eh = exp_hi_q.pop_front();
      el = exp_lo_q.pop_front();
      total++; if (ifc.hi !== eh) begin $display("FAIL arith%0d_hi: got %h want %h", k, ifc.hi, eh); bad++; end
      total++; if (ifc.lo !== el) begin $display("FAIL arith%0d_lo: got %h want %h", k, ifc.lo, el); bad++; end
      drive(1'b1, MD_MFHI, 32'd0, 32'd0);
      #1;
      total++; if (ifc.md_out !== eh) begin $display("FAIL arith%0d_mfhi: got %h want %h", k, ifc.md_out, eh); bad++; end
      drive(1'b1, MD_MFLO, 32'd0, 32'd0);
      #1;
      total++; if (ifc.md_out !== el) begin $display("FAIL arith%0d_mflo: got %h want %h", k, ifc.md_out, el); bad++; end
      drive(1'b0, MD_MFLO, 32'd0, 32'd0);
      tick();
    end
  endtask

  task automatic test_mtx();
    drive(1'b1, MD_MTHI, 32'h12345678, 32'd0);
    tick();
    m_hi = 32'h12345678;
    drive(1'b1, MD_MFHI, 32'd0, 32'd0);
    #1;
    total++; if (ifc.md_out !== 32'h12345678) begin $display("FAIL mthi_mfhi: got %h want 12345678", ifc.md_out); bad++; end
    drive(1'b1, MD_MTLO, 32'hCAFEF00D, 32'd0);
    tick();
    m_lo = 32'hCAFEF00D;
    total++; if (ifc.lo !== 32'hCAFEF00D) begin $display("FAIL mtlo_lo: got %h want cafef00d", ifc.lo); bad++; end
    total++; if (ifc.hi !== 32'h12345678) begin $display("FAIL mtlo_hi_kept: got %h want 12345678", ifc.hi); bad++; end
    drive(1'b0, MD_MFLO, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_mtlo_during_mult();
    logic [31:0] pre_hi, pre_lo, eh, el;
    bit          done;
    pre_hi = m_hi;
    pre_lo = m_lo;
    start_op(MD_MULT, 32'd7, 32'd9);
    tick();
    drive(1'b0, MD_MULT, 32'd0, 32'd0);
    tick();
    drive(1'b1, MD_MTLO, 32'h55555555, 32'd0);
    tick();
    drive(1'b1, MD_MFLO, 32'd0, 32'd0);
    #1;
    total++; if (ifc.md_out !== pre_lo) begin $display("FAIL busy_mflo: got %h want %h", ifc.md_out, pre_lo); bad++; end
    total++; if (ifc.lo !== pre_lo) begin $display("FAIL busy_mtlo_ignored: got %h want %h", ifc.lo, pre_lo); bad++; end
    drive(1'b1, MD_MFHI, 32'd0, 32'd0);
    #1;
    total++; if (ifc.md_out !== pre_hi) begin $display("FAIL busy_mfhi: got %h want %h", ifc.md_out, pre_hi); bad++; end
    drive(1'b0, MD_MFHI, 32'd0, 32'd0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      #1;
      if (ifc.busy === 1'b0) done = 1'b1;
    end
    total++; if (!done) begin $display("FAIL mtlo_mult_done: got busy=%b want 0", ifc.busy); bad++; end
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    total++; if (ifc.lo !== el) begin $display("FAIL mtlo_mult_lo: got %h want %h", ifc.lo, el); bad++; end
    total++; if (ifc.hi !== eh) begin $display("FAIL mtlo_mult_hi: got %h want %h", ifc.hi, eh); bad++; end
    tick();
  endtask

  task automatic test_back_to_back();
    int          n;
    bit          done;
    logic [31:0] eh, el;
    start_op(MD_MULT, 32'h00010000, 32'h00010000);
    #1;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ifc.busy === 1'b1) n++;
      else done = 1'b1;
      if (!done) begin
        tick();
        if (i == 1) drive(1'b1, MD_MULT, 32'd3, 32'd5);
        else drive(1'b0, MD_MULT, 32'd0, 32'd0);
        #1;
      end
    end
    total++;
    if (!done || n != 6) begin
      $display("FAIL b2b_busy_cycles: got %0d (done=%0b) want 6", n, done);
      bad++;
    end
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    total++; if (ifc.hi !== eh) begin $display("FAIL b2b_hi: got %h want %h", ifc.hi, eh); bad++; end
    total++; if (ifc.lo !== el) begin $display("FAIL b2b_lo: got %h want %h", ifc.lo, el); bad++; end
    tick();
  endtask

  task automatic test_reset_mid();
    int          n;
    bit          to;
    logic [31:0] eh, el;
    drive(1'b1, MD_DIV, 32'd100, 32'd3);
    #1;
    total++; if (ifc.busy !== 1'b1) begin $display("FAIL rmid_start_busy: got %b want 1", ifc.busy); bad++; end
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b0, MD_DIV, 32'd0, 32'd0);
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (ifc.busy !== 1'b0) begin $display("FAIL rmid_busy: got %b want 0", ifc.busy); bad++; end
    total++; if (ifc.hi !== 32'd0) begin $display("FAIL rmid_hi: got %h want 0", ifc.hi); bad++; end
    total++; if (ifc.lo !== 32'd0) begin $display("FAIL rmid_lo: got %h want 0", ifc.lo); bad++; end
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    reset = 1'b0;
    tick();
    start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    count_busy(n, to);
    total++;
    if (to || n != 6) begin
      $display("FAIL rmid_mult_busy_cycles: got %0d (timeout=%0b) want 6", n, to);
      bad++;
    end
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    total++; if (ifc.hi !== eh) begin $display("FAIL rmid_mult_hi: got %h want %h", ifc.hi, eh); bad++; end
    total++; if (ifc.lo !== el) begin $display("FAIL rmid_mult_lo: got %h want %h", ifc.lo, el); bad++; end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_en_low();
    test_arith();
    test_mtx();
    test_mtlo_during_mult();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
